ms_stopwatch: RTL
=================

Name: ms_stopwatch

Overview:
- Stopwatch core running in the 100 MHz domain; consumes the ~1 ms square wave from the millisecond clock divider (each edge, rising or falling, = one millisecond event).
- Accumulates elapsed time as BCD m:ss.hh with start/stop, clear and lap-hold control.
- Feeds the seven-segment display driver downstream.

Parameters:
- MS_PER_HUNDREDTH, 10, millisecond events per hundredth-second increment (benches use 1).
- SYNC_STAGES, 2, flops in the ms_clk_in synchronizer (legal values 2..3).

Ports:
- clock  in  1  100 MHz system clock
- reset_n  in  1  asynchronous, active-low reset
- ms_clk_in  in  1  divided ~1 ms clock from the divider; asynchronous to this block's logic, so synchronized here
- start_stop  in  1  single-cycle pulse; toggles running
- clear  in  1  single-cycle pulse; zero count, go idle
- lap  in  1  single-cycle pulse; toggles display freeze while running
- bcd_min  out  4  minutes digit, 0-9
- bcd_sec_tens  out  4  0-5
- bcd_sec_ones  out  4  0-9
- bcd_tenths  out  4  0-9
- bcd_hundredths  out  4  0-9
- running  out  1  high in RUNNING
- lap_hold  out  1  display frozen
- overflow  out  1  count saturated at 9:59.99
- hundredth_tick  out  1  one-cycle pulse on every hundredth increment

Behaviour:
- Reset (async assert, sync release):
  - all BCD outputs 0; running, lap_hold, overflow and hundredth_tick 0.
  - Sync flops, previous-sample flop and ms sub-counter 0; state IDLE.
- Tick detect:
  - ms_clk_in passes through SYNC_STAGES flops; tick = last sync stage XOR previous-sample register.
  - The counter acts on the clock edge after tick is seen. With SYNC_STAGES=2, an input edge before clock edge N updates the count at edge N+2 (3-edge worst case).
- Sub-counter:
  - Counts ticks 0..MS_PER_HUNDREDTH-1 only in RUNNING.
  - On a tick at MS_PER_HUNDREDTH-1: wraps to 0, increments the hundredths digit and pulses hundredth_tick.
- BCD carry chain: hundredths 9→0 carries to tenths; tenths 9→0 to sec_ones; sec_ones 9→0 to sec_tens; sec_tens 5→0 to min. No digit ever holds an illegal code.
- States:
  - IDLE: count zero, ticks ignored. start_stop → RUNNING.
  - RUNNING: ticks counted. start_stop → PAUSED. Increment from 9:59.99 → OVERFLOW.
  - PAUSED: ticks ignored, count and sub-counter held. start_stop → RUNNING.
  - OVERFLOW: count held at 9:59.99, overflow=1, start_stop and lap ignored.
- Clear: from any state, zero the count and sub-counter, clear lap_hold and overflow, go to IDLE.
- Lap:
  - In RUNNING, lap toggles lap_hold.
  - While lap_hold=1 the outputs keep the snapshot taken on the lap edge; internal counting continues.
  - lap_hold=0 → outputs track the live count on the same edge it updates.
  - Entering PAUSED keeps lap_hold.
  - lap is ignored in IDLE and PAUSED.
- Simultaneous events:
  - clear beats start_stop, lap and tick; a tick in the clear cycle is discarded.
  - start_stop plus tick in RUNNING: the tick is counted, then the block pauses.
  - start_stop plus lap in RUNNING: lap is applied (snapshot includes the tick of that cycle) and the block pauses.
  - Tick plus overflow transition: the count saturates and no wrap occurs.
- ms_clk_in high at reset release: the first detected transition occurs in IDLE and is ignored.
- Reset mid-run: immediate return to the reset values above; no partial state survives.

Test Plan:
- MS_PER_HUNDREDTH=1. Reset, start_stop, 25 ms_clk_in edges → digits 0:00.25, hundredth_tick pulsed 25 times, running=1, first update 3 edges after the input edge.
- Run to 0:59.99 then 1 more edge → 1:00.00; carry across all digits in the same cycle.
- Run 60000 edges → 9:59.99 with overflow=1; further edges and start_stop leave it unchanged; clear → 0:00.00, IDLE, overflow=0.
- At 0:00.10 pulse lap, apply 15 edges → outputs stay 0:00.10; pulse lap again → 0:00.25.
- start_stop to pause at 0:00.40, apply 10 edges → 0:00.40; start_stop, 5 edges → 0:00.45.
- Run to 0:00.07, then clear + start_stop + tick in the same cycle → 0:00.00, IDLE. Then assert reset_n low mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/ms_stopwatch.sv
// rtl/ms_stopwatch.sv - BCD m:ss.hh stopwatch core driven by a synchronized ~1 ms square wave.
// Both edges of ms_clk_in count as millisecond events; lap freezes the display while counting continues.
module ms_stopwatch #(
  parameter int MS_PER_HUNDREDTH = 10,
  parameter int SYNC_STAGES      = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ms_clk_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] bcd_min,
  output logic [3:0] bcd_sec_tens,
  output logic [3:0] bcd_sec_ones,
  output logic [3:0] bcd_tenths,
  output logic [3:0] bcd_hundredths,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow,
  output logic       hundredth_tick
);

  localparam int SUB_W = (MS_PER_HUNDREDTH > 1) ? $clog2(MS_PER_HUNDREDTH) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(MS_PER_HUNDREDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED, S_OVERFLOW} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [SUB_W-1:0]       r_sub;
  logic [3:0]             r_min, r_sec_tens, r_sec_ones, r_tenths, r_hund;
  logic [3:0]             r_snap_min, r_snap_sec_tens, r_snap_sec_ones, r_snap_tenths, r_snap_hund;
  logic                   r_lap_hold;
  logic                   r_htick;

  logic                   w_tick, w_wrap, w_at_max, w_inc;
  logic [3:0]             w_n_min, w_n_sec_tens, w_n_sec_ones, w_n_tenths, w_n_hund;

  assign w_tick   = r_sync[SYNC_STAGES-1] ^ r_prev;
  assign w_wrap   = (r_state == S_RUNNING) && w_tick && (r_sub == SUB_MAX);
  assign w_at_max = (r_min == 4'd9) && (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9) &&
                    (r_tenths == 4'd9) && (r_hund == 4'd9);
  assign w_inc    = w_wrap && !w_at_max;

  // Ripple carry through the digits; minutes never overflow because w_inc excludes 9:59.99.
  always_comb begin
    w_n_min      = r_min;
    w_n_sec_tens = r_sec_tens;
    w_n_sec_ones = r_sec_ones;
    w_n_tenths   = r_tenths;
    w_n_hund     = r_hund;
    if (w_inc) begin
      if (r_hund != 4'd9) w_n_hund = r_hund + 4'd1;
      else begin
        w_n_hund = 4'd0;
        if (r_tenths != 4'd9) w_n_tenths = r_tenths + 4'd1;
        else begin
          w_n_tenths = 4'd0;
          if (r_sec_ones != 4'd9) w_n_sec_ones = r_sec_ones + 4'd1;
          else begin
            w_n_sec_ones = 4'd0;
            if (r_sec_tens != 4'd5) w_n_sec_tens = r_sec_tens + 4'd1;
            else begin
              w_n_sec_tens = 4'd0;
              w_n_min      = r_min + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_sync          <= '0;
      r_prev          <= 1'b0;
      r_sub           <= '0;
      r_min           <= 4'd0;
      r_sec_tens      <= 4'd0;
      r_sec_ones      <= 4'd0;
      r_tenths        <= 4'd0;
      r_hund          <= 4'd0;
      r_snap_min      <= 4'd0;
      r_snap_sec_tens <= 4'd0;
      r_snap_sec_ones <= 4'd0;
      r_snap_tenths   <= 4'd0;
      r_snap_hund     <= 4'd0;
      r_lap_hold      <= 1'b0;
      r_htick         <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], ms_clk_in};
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_htick <= 1'b0;
      if (clear) begin
        r_state    <= S_IDLE;
        r_sub      <= '0;
        r_min      <= 4'd0;
        r_sec_tens <= 4'd0;
        r_sec_ones <= 4'd0;
        r_tenths   <= 4'd0;
        r_hund     <= 4'd0;
        r_lap_hold <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_PAUSED: begin
            if (start_stop) r_state <= S_RUNNING;
          end
          S_RUNNING: begin
            if (w_tick) r_sub <= (r_sub == SUB_MAX) ? '0 : r_sub + SUB_W'(1);
            r_min      <= w_n_min;
            r_sec_tens <= w_n_sec_tens;
            r_sec_ones <= w_n_sec_ones;
            r_tenths   <= w_n_tenths;
            r_hund     <= w_n_hund;
            r_htick    <= w_inc;
            // The snapshot takes the post-increment count so a same-cycle tick is included.
            if (lap) begin
              r_lap_hold      <= ~r_lap_hold;
              r_snap_min      <= w_n_min;
              r_snap_sec_tens <= w_n_sec_tens;
              r_snap_sec_ones <= w_n_sec_ones;
              r_snap_tenths   <= w_n_tenths;
              r_snap_hund     <= w_n_hund;
            end
            if (w_wrap && w_at_max) r_state <= S_OVERFLOW;
            else if (start_stop)    r_state <= S_PAUSED;
          end
          default: ;
        endcase
      end
    end
  end

  assign bcd_min        = r_lap_hold ? r_snap_min      : r_min;
  assign bcd_sec_tens   = r_lap_hold ? r_snap_sec_tens : r_sec_tens;
  assign bcd_sec_ones   = r_lap_hold ? r_snap_sec_ones : r_sec_ones;
  assign bcd_tenths     = r_lap_hold ? r_snap_tenths   : r_tenths;
  assign bcd_hundredths = r_lap_hold ? r_snap_hund     : r_hund;
  assign running        = (r_state == S_RUNNING);
  assign overflow       = (r_state == S_OVERFLOW);
  assign lap_hold       = r_lap_hold;
  assign hundredth_tick = r_htick;

endmodule
